// File: rtl/byte_word_loader_pkg.sv
// rtl/byte_word_loader_pkg.sv - shared types and constants for the byte-to-word RAM loader
package byte_word_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DATA_W         = 32;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  localparam logic SEL_IMEM = 1'b0;
  localparam logic SEL_DMEM = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } loader_state_e;

endpackage

// File: rtl/pulse_sync_edge.sv
// rtl/pulse_sync_edge.sv - two-flop synchronizer plus registered rising-edge pulse
module pulse_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic pulse_o
);

  logic [2:0] sync_q;

  // sync_q[2] is the previous synchronized level; pulse is registered, giving 3 cycles of latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      pulse_o <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], level_i};
      pulse_o <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

// File: rtl/byte_word_loader.sv
// rtl/byte_word_loader.sv - packs switch bytes little-endian into 32-bit words and writes IMEM or DMEM
// Optional BYTE_LOADER_SYNC_EN: strobe inputs are raw button levels, synchronized and edge-detected.
module byte_word_loader
  import byte_word_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start_i,
  input  logic              load_end_i,
  input  logic              sel_dmem_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              imem_we_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              cpu_hold_o,
  output logic              load_done_o,
  output logic              overflow_o,
  output logic [ADDR_W:0]   word_count_o
);

  logic start_p;
  logic end_p;
  logic byte_p;

`ifdef BYTE_LOADER_SYNC_EN
  pulse_sync_edge u_sync_start (
    .clk     (clk),
    .reset   (reset),
    .level_i (load_start_i),
    .pulse_o (start_p)
  );
  pulse_sync_edge u_sync_end (
    .clk     (clk),
    .reset   (reset),
    .level_i (load_end_i),
    .pulse_o (end_p)
  );
  pulse_sync_edge u_sync_byte (
    .clk     (clk),
    .reset   (reset),
    .level_i (byte_valid_i),
    .pulse_o (byte_p)
  );
`else
  assign start_p = load_start_i;
  assign end_p   = load_end_i;
  assign byte_p  = byte_valid_i;
`endif

  loader_state_e     state;
  logic              sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  byte_cnt;
  logic [DATA_W-1:0] asm_q;
  logic              end_pend;

  logic              take_byte;
  logic              word_full;
  logic              go_flush;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] asm_ins;
  logic [DATA_W-1:0] flush_word;

  // end_pend in COLLECT means the session is closing; no further bytes are taken
  always_comb begin
    take_byte = byte_p && ((state == ST_WRITE) || (state == ST_COLLECT && !end_pend));
    cnt_inc   = byte_cnt + CNT_W'(1);
    asm_ins   = asm_q;
    asm_ins[8*int'(byte_cnt) +: 8] = byte_i;
    word_full = take_byte && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));
    go_flush  = end_pend || (end_p && !word_full && (take_byte || byte_cnt != '0));
    flush_word = take_byte ? asm_ins : asm_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      sel_q        <= SEL_IMEM;
      addr_q       <= '0;
      byte_cnt     <= '0;
      asm_q        <= '0;
      end_pend     <= 1'b0;
      imem_we_o    <= 1'b0;
      dmem_we_o    <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      cpu_hold_o   <= 1'b0;
      load_done_o  <= 1'b0;
      overflow_o   <= 1'b0;
      word_count_o <= '0;
    end else begin
      imem_we_o   <= 1'b0;
      dmem_we_o   <= 1'b0;
      load_done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_p) begin
            sel_q        <= sel_dmem_i;
            addr_q       <= start_addr_i;
            word_count_o <= '0;
            overflow_o   <= 1'b0;
            byte_cnt     <= '0;
            asm_q        <= '0;
            end_pend     <= 1'b0;
            cpu_hold_o   <= 1'b1;
            state        <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (word_full) begin
            mem_wdata_o <= asm_ins;
            mem_addr_o  <= addr_q;
            imem_we_o   <= (sel_q == SEL_IMEM);
            dmem_we_o   <= (sel_q == SEL_DMEM);
            asm_q       <= '0;
            byte_cnt    <= '0;
            end_pend    <= end_p;
            state       <= ST_WRITE;
          end else if (go_flush) begin
            mem_wdata_o <= flush_word;
            mem_addr_o  <= addr_q;
            imem_we_o   <= (sel_q == SEL_IMEM);
            dmem_we_o   <= (sel_q == SEL_DMEM);
            asm_q       <= '0;
            byte_cnt    <= '0;
            end_pend    <= 1'b0;
            state       <= ST_FLUSH;
          end else if (end_p) begin
            load_done_o <= 1'b1;
            state       <= ST_DONE;
          end else if (take_byte) begin
            asm_q    <= asm_ins;
            byte_cnt <= cnt_inc;
          end
        end
        ST_WRITE: begin
          addr_q       <= addr_q + ADDR_W'(1);
          word_count_o <= word_count_o + (ADDR_W+1)'(1);
          if (&addr_q) overflow_o <= 1'b1;
          if (take_byte) begin
            asm_q    <= asm_ins;
            byte_cnt <= cnt_inc;
          end
          // A byte landing with the end must flush, but one idle cycle keeps write enables apart
          if (end_p || end_pend) begin
            if (take_byte) begin
              end_pend <= 1'b1;
              state    <= ST_COLLECT;
            end else begin
              end_pend    <= 1'b0;
              load_done_o <= 1'b1;
              state       <= ST_DONE;
            end
          end else begin
            state <= ST_COLLECT;
          end
        end
        ST_FLUSH: begin
          addr_q       <= addr_q + ADDR_W'(1);
          word_count_o <= word_count_o + (ADDR_W+1)'(1);
          if (&addr_q) overflow_o <= 1'b1;
          load_done_o  <= 1'b1;
          state        <= ST_DONE;
        end
        ST_DONE: begin
          cpu_hold_o <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          cpu_hold_o <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_word_loader.sv
// tb/tb_byte_word_loader.sv - directed self-checking bench for byte_word_loader
module tb_byte_word_loader;

  logic        clk;
  logic        reset;
  logic        load_start_i;
  logic        load_end_i;
  logic        sel_dmem_i;
  logic [9:0]  start_addr_i;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        imem_we_o;
  logic        dmem_we_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        cpu_hold_o;
  logic        load_done_o;
  logic        overflow_o;
  logic [10:0] word_count_o;

  int checks = 0;
  int errors = 0;

  byte_word_loader #(.ADDR_W(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start_i (load_start_i),
    .load_end_i   (load_end_i),
    .sel_dmem_i   (sel_dmem_i),
    .start_addr_i (start_addr_i),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .imem_we_o    (imem_we_o),
    .dmem_we_o    (dmem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .cpu_hold_o   (cpu_hold_o),
    .load_done_o  (load_done_o),
    .overflow_o   (overflow_o),
    .word_count_o (word_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write log: {is_dmem, addr, data}
  logic [42:0] wr_log[$];
  int          done_cnt = 0;
  int          we_rule_viol = 0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (imem_we_o || dmem_we_o) wr_log.push_back({dmem_we_o, mem_addr_o, mem_wdata_o});
    if (load_done_o) done_cnt++;
    if ((imem_we_o || dmem_we_o) && prev_we) we_rule_viol++;
    if (imem_we_o && dmem_we_o) we_rule_viol++;
    prev_we = imem_we_o || dmem_we_o;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_start(input logic sel, input logic [9:0] addr);
    load_start_i = 1'b1; sel_dmem_i = sel; start_addr_i = addr;
    step();
    load_start_i = 1'b0;
  endtask

  task automatic do_byte(input logic [7:0] b);
    byte_valid_i = 1'b1; byte_i = b;
    step();
    byte_valid_i = 1'b0;
  endtask

  task automatic do_end();
    load_end_i = 1'b1;
    step();
    load_end_i = 1'b0;
  endtask

  task automatic clear_log();
    wr_log.delete();
    done_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle(2);
    checks++;
    if ({imem_we_o, dmem_we_o, mem_addr_o, mem_wdata_o, cpu_hold_o, load_done_o, overflow_o, word_count_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b%b addr=%h data=%h hold=%b done=%b ovf=%b cnt=%0d want all 0",
               imem_we_o, dmem_we_o, mem_addr_o, mem_wdata_o, cpu_hold_o, load_done_o, overflow_o, word_count_o);
    end
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_full_words();
    logic [7:0] bytes [8] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    clear_log();
    do_start(1'b0, 10'h010);
    checks++;
    if (cpu_hold_o !== 1'b1) begin errors++; $display("FAIL full_hold_on: got %b want 1", cpu_hold_o); end
    for (int i = 0; i < 8; i++) do_byte(bytes[i]);
    do_end();
    idle(4);
    checks++;
    if (wr_log.size() != 2) begin errors++; $display("FAIL full_write_count: got %0d want 2", wr_log.size()); end
    else begin
      checks++;
      if (wr_log[0] !== {1'b0, 10'h010, 32'h00500013}) begin errors++; $display("FAIL full_word0: got %h want %h", wr_log[0], {1'b0, 10'h010, 32'h00500013}); end
      checks++;
      if (wr_log[1] !== {1'b0, 10'h011, 32'hDDCCBBAA}) begin errors++; $display("FAIL full_word1: got %h want %h", wr_log[1], {1'b0, 10'h011, 32'hDDCCBBAA}); end
    end
    checks++;
    if (word_count_o !== 11'd2) begin errors++; $display("FAIL full_word_count: got %0d want 2", word_count_o); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL full_done_pulses: got %0d want 1", done_cnt); end
    checks++;
    if (cpu_hold_o !== 1'b0) begin errors++; $display("FAIL full_hold_off: got %b want 0", cpu_hold_o); end
  endtask

  task automatic test_partial_flush();
    clear_log();
    do_start(1'b1, 10'h000);
    do_byte(8'h11);
    do_byte(8'h22);
    do_end();
    idle(4);
    checks++;
    if (wr_log.size() != 1) begin errors++; $display("FAIL flush_write_count: got %0d want 1", wr_log.size()); end
    else begin
      checks++;
      if (wr_log[0] !== {1'b1, 10'h000, 32'h00002211}) begin errors++; $display("FAIL flush_word: got %h want %h", wr_log[0], {1'b1, 10'h000, 32'h00002211}); end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL flush_done_pulses: got %0d want 1", done_cnt); end
    checks++;
    if (word_count_o !== 11'd1) begin errors++; $display("FAIL flush_word_count: got %0d want 1", word_count_o); end
  endtask

  task automatic test_wrap();
    clear_log();
    do_start(1'b0, 10'h3FF);
    checks++;
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL wrap_ovf_start: got %b want 0", overflow_o); end
    for (int i = 1; i <= 8; i++) do_byte(8'(i));
    do_end();
    idle(4);
    checks++;
    if (wr_log.size() != 2) begin errors++; $display("FAIL wrap_write_count: got %0d want 2", wr_log.size()); end
    else begin
      checks++;
      if (wr_log[0] !== {1'b0, 10'h3FF, 32'h04030201}) begin errors++; $display("FAIL wrap_word0: got %h want %h", wr_log[0], {1'b0, 10'h3FF, 32'h04030201}); end
      checks++;
      if (wr_log[1] !== {1'b0, 10'h000, 32'h08070605}) begin errors++; $display("FAIL wrap_word1: got %h want %h", wr_log[1], {1'b0, 10'h000, 32'h08070605}); end
    end
    checks++;
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL wrap_ovf_sticky: got %b want 1", overflow_o); end
    do_start(1'b0, 10'h000);
    checks++;
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL wrap_ovf_cleared: got %b want 0", overflow_o); end
    do_end();
    idle(3);
  endtask

  task automatic test_same_cycle_end();
    clear_log();
    do_start(1'b0, 10'h020);
    do_byte(8'hA1);
    do_byte(8'hA2);
    do_byte(8'hA3);
    byte_valid_i = 1'b1; byte_i = 8'hA4; load_end_i = 1'b1;
    step();
    byte_valid_i = 1'b0; load_end_i = 1'b0;
    checks++;
    if (imem_we_o !== 1'b1) begin errors++; $display("FAIL same_we_latency: got %b want 1", imem_we_o); end
    checks++;
    if (load_done_o !== 1'b0) begin errors++; $display("FAIL same_done_early: got %b want 0", load_done_o); end
    step();
    checks++;
    if (load_done_o !== 1'b1) begin errors++; $display("FAIL same_done_timing: got %b want 1", load_done_o); end
    idle(3);
    checks++;
    if (wr_log.size() != 1) begin errors++; $display("FAIL same_write_count: got %0d want 1", wr_log.size()); end
    else begin
      checks++;
      if (wr_log[0] !== {1'b0, 10'h020, 32'hA4A3A2A1}) begin errors++; $display("FAIL same_word: got %h want %h", wr_log[0], {1'b0, 10'h020, 32'hA4A3A2A1}); end
    end
    checks++;
    if (word_count_o !== 11'd1) begin errors++; $display("FAIL same_word_count: got %0d want 1", word_count_o); end
  endtask

  task automatic test_reset_mid_session();
    clear_log();
    do_start(1'b1, 10'h040);
    do_byte(8'h55);
    do_byte(8'h66);
    reset = 1'b0;
    #2;
    checks++;
    if ({imem_we_o, dmem_we_o, mem_addr_o, mem_wdata_o, cpu_hold_o, load_done_o, overflow_o, word_count_o} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got hold=%b addr=%h data=%h cnt=%0d want all 0", cpu_hold_o, mem_addr_o, mem_wdata_o, word_count_o);
    end
    step();
    reset = 1'b1;
    idle(4);
    checks++;
    if (wr_log.size() != 0 || done_cnt != 0) begin errors++; $display("FAIL midreset_no_write: got writes=%0d done=%0d want 0 0", wr_log.size(), done_cnt); end
    do_start(1'b1, 10'h005);
    do_byte(8'h01);
    do_byte(8'h23);
    do_byte(8'h45);
    do_byte(8'h67);
    do_end();
    idle(4);
    checks++;
    if (wr_log.size() != 1) begin errors++; $display("FAIL midreset_reload_count: got %0d want 1", wr_log.size()); end
    else begin
      checks++;
      if (wr_log[0] !== {1'b1, 10'h005, 32'h67452301}) begin errors++; $display("FAIL midreset_reload_word: got %h want %h", wr_log[0], {1'b1, 10'h005, 32'h67452301}); end
    end
  endtask

  task automatic test_ignored_and_write_byte();
    clear_log();
    do_byte(8'hFF);
    do_byte(8'hEE);
    do_end();
    idle(2);
    checks++;
    if (wr_log.size() != 0 || done_cnt != 0 || cpu_hold_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignored: got writes=%0d done=%0d hold=%b want 0 0 0", wr_log.size(), done_cnt, cpu_hold_o);
    end
    do_start(1'b0, 10'h100);
    do_byte(8'h10);
    do_byte(8'h20);
    do_start(1'b1, 10'h200);
    do_byte(8'h30);
    do_byte(8'h40);
    do_byte(8'h50);
    do_byte(8'h60);
    do_end();
    idle(4);
    checks++;
    if (wr_log.size() != 2) begin errors++; $display("FAIL ign_write_count: got %0d want 2", wr_log.size()); end
    else begin
      checks++;
      if (wr_log[0] !== {1'b0, 10'h100, 32'h40302010}) begin errors++; $display("FAIL ign_word0: got %h want %h", wr_log[0], {1'b0, 10'h100, 32'h40302010}); end
      checks++;
      if (wr_log[1] !== {1'b0, 10'h101, 32'h00006050}) begin errors++; $display("FAIL ign_write_byte0: got %h want %h", wr_log[1], {1'b0, 10'h101, 32'h00006050}); end
    end
    checks++;
    if (word_count_o !== 11'd2) begin errors++; $display("FAIL ign_word_count: got %0d want 2", word_count_o); end
  endtask

  task automatic test_we_rules();
    checks++;
    if (we_rule_viol != 0) begin errors++; $display("FAIL we_rules: got %0d violations want 0", we_rule_viol); end
  endtask

  initial begin
    reset = 1'b0; load_start_i = 1'b0; load_end_i = 1'b0; sel_dmem_i = 1'b0;
    start_addr_i = '0; byte_valid_i = 1'b0; byte_i = '0;
    test_reset();
    test_full_words();
    test_partial_flush();
    test_wrap();
    test_same_cycle_end();
    test_reset_mid_session();
    test_ignored_and_write_byte();
    test_we_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
